// File: rtl/cfgport_responder.sv
// cfgport_responder: configuration-port slave with sync-word detection, type-1 packet
// decode, a 32 x 32 register file and latency-pipelined readback.
module cfgport_responder #(
  parameter logic [31:0] IDCODE  = 32'h0362d093,
  parameter int unsigned RDLAT   = 3,
  parameter int unsigned BITSWAP = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_csib,
  input  logic        i_rdwrb,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_synced,
  output logic        o_iprog,
  output logic [31:0] o_wbstar,
  output logic        o_err
);

  localparam logic [31:0] SyncWord   = 32'haa995566;
  localparam logic [31:0] CmdDesync  = 32'h0000000d;
  localparam logic [31:0] CmdIprog   = 32'h0000000f;
  localparam logic [4:0]  AddrCmd    = 5'h04;
  localparam logic [4:0]  AddrIdcode = 5'h0c;
  localparam logic [4:0]  AddrWbstar = 5'h10;

  typedef enum logic [2:0] {StUnsync, StHdr, StWrData, StRdPend, StRdOut} state_e;

  state_e      r_state;
  logic [10:0] r_count;
  logic [2:0]  r_lat;
  logic [4:0]  r_addr;
  logic [31:0] r_regs [32];
  logic [31:0] r_data;
  logic        r_synced;
  logic        r_iprog;
  logic        r_err;
  logic        r_prev_csib;
  logic        r_prev_rdwrb;

  logic [31:0] w_din;
  logic [31:0] w_rdval;
  logic        w_wr;
  logic        w_rd;
  logic        w_dir_chg;
  logic        w_take_hdr;
  logic        w_cmd_exit;
  logic [3:0]  w_lat_next;
  state_e      w_hdr_next;
  logic        w_hdr_err;
  logic        w_hdr_load;

  function automatic logic [31:0] f_swap(input logic [31:0] w);
    logic [31:0] v_out;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        v_out[8*b+i] = w[8*b+7-i];
      end
    end
    return v_out;
  endfunction

  assign w_din      = (BITSWAP != 0) ? f_swap(i_data) : i_data;
  assign o_data     = (BITSWAP != 0) ? f_swap(r_data) : r_data;
  assign o_synced   = r_synced;
  assign o_iprog    = r_iprog;
  assign o_err      = r_err;
  assign o_wbstar   = r_regs[AddrWbstar];

  assign w_wr       = !i_csib && !i_rdwrb;
  assign w_rd       = !i_csib && i_rdwrb;
  // Direction flip inside one continuous select window is a protocol error.
  assign w_dir_chg  = !i_csib && !r_prev_csib && (i_rdwrb != r_prev_rdwrb);
  // A write arriving in a read phase right after a deselect gap restarts as a header.
  assign w_take_hdr = w_wr && ((r_state == StHdr) ||
                      (((r_state == StRdPend) || (r_state == StRdOut)) && r_prev_csib));
  assign w_cmd_exit = (r_addr == AddrCmd) && ((w_din == CmdDesync) || (w_din == CmdIprog));
  assign w_lat_next = {1'b0, r_lat} + 4'd1;

  always_comb begin
    w_rdval = r_regs[r_addr];
    if (r_addr == AddrCmd) begin
      w_rdval = '0;
    end else if (r_addr == AddrIdcode) begin
      w_rdval = IDCODE;
    end
  end

  always_comb begin
    w_hdr_next = StHdr;
    w_hdr_err  = 1'b0;
    w_hdr_load = 1'b0;
    if (w_din != 32'hffffffff) begin
      if (w_din[31:29] != 3'b001) begin
        w_hdr_err = 1'b1;
      end else begin
        case (w_din[28:27])
          2'b00: w_hdr_err = 1'b0;
          2'b10: begin
            if (w_din[10:0] != 11'd0) begin
              w_hdr_next = StWrData;
              w_hdr_load = 1'b1;
            end
          end
          2'b01: begin
            if (w_din[10:0] != 11'd0) begin
              w_hdr_next = StRdPend;
              w_hdr_load = 1'b1;
            end
          end
          default: w_hdr_err = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= StUnsync;
      r_count      <= '0;
      r_lat        <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_synced     <= 1'b0;
      r_iprog      <= 1'b0;
      r_err        <= 1'b0;
      r_prev_csib  <= 1'b1;
      r_prev_rdwrb <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_iprog      <= 1'b0;
      r_prev_csib  <= i_csib;
      r_prev_rdwrb <= i_rdwrb;
      if (w_dir_chg) begin
        r_err <= 1'b1;
        if (r_state != StUnsync) begin
          r_state <= StHdr;
        end
      end else if (w_take_hdr) begin
        r_state <= w_hdr_next;
        if (w_hdr_err) begin
          r_err <= 1'b1;
        end
        if (w_hdr_load) begin
          r_count <= w_din[10:0];
          r_addr  <= w_din[17:13];
          r_lat   <= '0;
        end
      end else if (!i_csib) begin
        case (r_state)
          StUnsync: begin
            if (w_wr && (w_din == SyncWord)) begin
              r_state  <= StHdr;
              r_synced <= 1'b1;
            end
          end
          StWrData: begin
            if (w_wr) begin
              if ((r_addr != AddrCmd) && (r_addr != AddrIdcode)) begin
                r_regs[r_addr] <= w_din;
              end
              r_count <= r_count - 11'd1;
              if (w_cmd_exit) begin
                r_state  <= StUnsync;
                r_synced <= 1'b0;
                r_count  <= '0;
                r_iprog  <= (w_din == CmdIprog);
              end else if (r_count == 11'd1) begin
                r_state <= StHdr;
              end
            end
          end
          StRdPend: begin
            if (w_rd) begin
              if (w_lat_next == 4'(RDLAT)) begin
                r_data  <= w_rdval;
                r_lat   <= '0;
                r_count <= r_count - 11'd1;
                r_state <= (r_count == 11'd1) ? StHdr : StRdOut;
              end else begin
                r_lat <= w_lat_next[2:0];
              end
            end
          end
          StRdOut: begin
            if (w_rd) begin
              r_data  <= w_rdval;
              r_count <= r_count - 11'd1;
              if (r_count == 11'd1) begin
                r_state <= StHdr;
              end
            end
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cfgport_responder.sv
// tb_cfgport_responder: vector table, directed multi-cycle sequences and randomized
// packets compared against a transaction-level reference model.
module tb_cfgport_responder;

  localparam logic [31:0] IDC   = 32'h0362d093;
  localparam int          RDLAT = 3;
  localparam logic [31:0] SYNC  = 32'haa995566;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csib = 1'b1;
  logic        rdwrb = 1'b1;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic [31:0] wbstar;
  logic        synced;
  logic        iprog;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  cfgport_responder #(
    .IDCODE (IDC),
    .RDLAT  (RDLAT),
    .BITSWAP(1)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .i_csib   (csib),
    .i_rdwrb  (rdwrb),
    .i_data   (din),
    .o_data   (dout),
    .o_synced (synced),
    .o_iprog  (iprog),
    .o_wbstar (wbstar),
    .o_err    (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] swap(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[8*b+i] = w[8*b+7-i];
      end
    end
    return r;
  endfunction

  // Reference model: packet-level view in logical (un-swapped) words.
  bit          m_synced, m_iprog, m_err, m_pcs, m_prw;
  logic [31:0] m_data;
  logic [31:0] m_regs [32];
  string       m_phase;
  int          m_left, m_seen;
  logic [4:0]  m_addr;

  task automatic m_reset();
    m_synced = 0; m_iprog = 0; m_err = 0; m_data = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_phase = "unsync"; m_left = 0; m_seen = 0; m_addr = '0;
    m_pcs = 1; m_prw = 0;
  endtask

  function automatic logic [31:0] m_readreg(input logic [4:0] a);
    if (a == 5'd4) return '0;
    if (a == 5'd12) return IDC;
    return m_regs[a];
  endfunction

  task automatic m_header(input logic [31:0] w);
    int cnt;
    m_phase = "hdr";
    if (w == 32'hffffffff) return;
    if (w[31:29] != 3'b001) begin m_err = 1; return; end
    cnt = int'(w[10:0]);
    if (w[28:27] == 2'b11) m_err = 1;
    else if (w[28:27] == 2'b10 && cnt > 0) begin
      m_phase = "wr"; m_left = cnt; m_addr = w[17:13];
    end else if (w[28:27] == 2'b01 && cnt > 0) begin
      m_phase = "rdwait"; m_left = cnt; m_seen = 0; m_addr = w[17:13];
    end
  endtask

  task automatic m_step(input bit cs, input bit rw, input logic [31:0] w);
    bit gap, chg;
    gap = m_pcs;
    chg = !cs && !m_pcs && (rw != m_prw);
    m_pcs = cs; m_prw = rw; m_iprog = 0;
    if (chg) begin
      m_err = 1;
      if (m_phase != "unsync") m_phase = "hdr";
    end else if (!cs && !rw) begin
      if (m_phase == "unsync") begin
        if (w == SYNC) begin m_phase = "hdr"; m_synced = 1; end
      end else if (m_phase == "hdr") begin
        m_header(w);
      end else if (m_phase == "wr") begin
        if (m_addr != 5'd4 && m_addr != 5'd12) m_regs[m_addr] = w;
        m_left--;
        if (m_left == 0) m_phase = "hdr";
        if (m_addr == 5'd4 && (w == 32'hd || w == 32'hf)) begin
          m_phase = "unsync"; m_synced = 0; m_iprog = (w == 32'hf);
        end
      end else if (gap) begin
        m_header(w);
      end
    end else if (!cs && rw) begin
      if (m_phase == "rdwait") begin
        m_seen++;
        if (m_seen == RDLAT) begin
          m_data = m_readreg(m_addr); m_left--;
          m_phase = (m_left == 0) ? "hdr" : "rdout";
        end
      end else if (m_phase == "rdout") begin
        m_data = m_readreg(m_addr); m_left--;
        if (m_left == 0) m_phase = "hdr";
      end
    end
  endtask

  bit use_model = 0;

  task automatic check_all(input string name);
    n_tests++;
    if (dout !== swap(m_data) || synced !== m_synced || iprog !== m_iprog ||
        err !== m_err || wbstar !== m_regs[16]) begin
      n_fail++;
      $display("FAIL %s: got data=%h synced=%b iprog=%b err=%b wbstar=%h, expected data=%h synced=%b iprog=%b err=%b wbstar=%h",
               name, dout, synced, iprog, err, wbstar, swap(m_data), m_synced, m_iprog,
               m_err, m_regs[16]);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: inputs applied at negedge, model stepped at posedge, sampled at next negedge.
  task automatic cyc(input bit cs, input bit rw, input logic [31:0] w);
    csib = cs; rdwrb = rw; din = swap(w);
    @(posedge clk);
    m_step(cs, rw, w);
    @(negedge clk);
    if (use_model) check_all("rand");
  endtask

  task automatic rcyc(input bit rw, input logic [31:0] w);
    if ($urandom_range(0, 5) == 0) cyc(1'b1, 1'($urandom), $urandom);
    cyc(1'b0, rw, w);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    string       name;
    bit          cs;
    bit          rw;
    logic [31:0] w;
    bit          e_sync;
    bit          e_iprog;
    bit          e_err;
    logic [31:0] e_wb;
    logic [31:0] e_data;
  } vec_t;

  function automatic vec_t v(input string n, input bit cs, input bit rw, input logic [31:0] w,
                             input bit s, input bit ip, input bit er, input logic [31:0] wb,
                             input logic [31:0] d);
    vec_t r;
    r.name = n; r.cs = cs; r.rw = rw; r.w = w; r.e_sync = s; r.e_iprog = ip;
    r.e_err = er; r.e_wb = wb; r.e_data = d;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [4:0]  a;
    logic [10:0] n;
    logic [31:0] d;
    int          sel;

    m_reset();
    tbl.push_back(v("r031_ff",     0, 0, 32'hffffffff, 0, 0, 0, 32'h0,        32'h0));
    tbl.push_back(v("r031_noop0",  0, 0, 32'h20000000, 0, 0, 0, 32'h0,        32'h0));
    tbl.push_back(v("r031_sync",   0, 0, SYNC,         1, 0, 0, 32'h0,        32'h0));
    tbl.push_back(v("r031_noop1",  0, 0, 32'h20000000, 1, 0, 0, 32'h0,        32'h0));
    tbl.push_back(v("r031_hdr",    0, 0, 32'h30020001, 1, 0, 0, 32'h0,        32'h0));
    tbl.push_back(v("r031_wb",     0, 0, 32'h00400000, 1, 0, 0, 32'h00400000, 32'h0));
    tbl.push_back(v("r032_hdr",    0, 0, 32'h30008001, 1, 0, 0, 32'h00400000, 32'h0));
    tbl.push_back(v("r032_iprog",  0, 0, 32'h0000000f, 0, 1, 0, 32'h00400000, 32'h0));
    tbl.push_back(v("r032_after",  0, 0, 32'h30020001, 0, 0, 0, 32'h00400000, 32'h0));
    tbl.push_back(v("r032_ign",    0, 0, 32'h00000001, 0, 0, 0, 32'h00400000, 32'h0));
    tbl.push_back(v("r033_sync",   0, 0, SYNC,         1, 0, 0, 32'h00400000, 32'h0));
    tbl.push_back(v("r033_hdr",    0, 0, 32'h28018001, 1, 0, 0, 32'h00400000, 32'h0));
    tbl.push_back(v("r033_noop",   0, 0, 32'h20000000, 1, 0, 0, 32'h00400000, 32'h0));
    tbl.push_back(v("r033_gap",    1, 1, 32'h0,        1, 0, 0, 32'h00400000, 32'h0));
    tbl.push_back(v("r033_rd1",    0, 1, 32'h0,        1, 0, 0, 32'h00400000, 32'h0));
    tbl.push_back(v("r033_rd2",    0, 1, 32'h0,        1, 0, 0, 32'h00400000, 32'h0));
    tbl.push_back(v("r033_rd3",    0, 1, 32'h0,        1, 0, 0, 32'h00400000, IDC));
    tbl.push_back(v("r033_hdrrd",  0, 1, 32'h0,        1, 0, 0, 32'h00400000, IDC));
    tbl.push_back(v("r033_gap2",   1, 0, 32'h0,        1, 0, 0, 32'h00400000, IDC));
    tbl.push_back(v("r033_wrhdr",  0, 0, 32'h30020001, 1, 0, 0, 32'h00400000, IDC));
    tbl.push_back(v("r033_wr",     0, 0, 32'h12345678, 1, 0, 0, 32'h12345678, IDC));
    tbl.push_back(v("r034_hdr",    0, 0, 32'h30020002, 1, 0, 0, 32'h12345678, IDC));
    tbl.push_back(v("r034_w1",     0, 0, 32'h11111111, 1, 0, 0, 32'h11111111, IDC));
    tbl.push_back(v("r034_w2",     0, 0, 32'h22222222, 1, 0, 0, 32'h22222222, IDC));
    tbl.push_back(v("r035_hdr",    0, 0, 32'h30020002, 1, 0, 0, 32'h22222222, IDC));
    tbl.push_back(v("r035_w1",     0, 0, 32'h11111111, 1, 0, 0, 32'h11111111, IDC));
    tbl.push_back(v("r035_flip",   0, 1, 32'h99999999, 1, 0, 1, 32'h11111111, IDC));
    tbl.push_back(v("r035_gap",    1, 0, 32'h0,        1, 0, 1, 32'h11111111, IDC));
    tbl.push_back(v("r035_hdr2",   0, 0, 32'h30020001, 1, 0, 1, 32'h11111111, IDC));
    tbl.push_back(v("r035_w",      0, 0, 32'h33333333, 1, 0, 1, 32'h33333333, IDC));

    #3;
    chk("rst_data", dout, 32'h0);
    chk("rst_flags", {29'd0, synced, iprog, err}, 32'h0);
    chk("rst_wbstar", wbstar, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      cyc(tbl[k].cs, tbl[k].rw, tbl[k].w);
      n_tests++;
      if (dout !== swap(tbl[k].e_data) || synced !== tbl[k].e_sync ||
          iprog !== tbl[k].e_iprog || err !== tbl[k].e_err || wbstar !== tbl[k].e_wb) begin
        n_fail++;
        $display("FAIL %s: got data=%h synced=%b iprog=%b err=%b wbstar=%h, expected data=%h synced=%b iprog=%b err=%b wbstar=%h",
                 tbl[k].name, dout, synced, iprog, err, wbstar, swap(tbl[k].e_data),
                 tbl[k].e_sync, tbl[k].e_iprog, tbl[k].e_err, tbl[k].e_wb);
      end
    end

    // Asynchronous reset in the middle of a write packet.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, SYNC);
    cyc(0, 0, 32'h28018001);
    cyc(0, 0, 32'h20000000);
    cyc(1, 1, 32'h0);
    repeat (3) cyc(0, 1, 32'h0);
    cyc(1, 0, 32'h0);
    cyc(0, 0, 32'h60000000);
    cyc(0, 0, 32'h30020002);
    cyc(0, 0, 32'h11111111);
    chk("r036_pre_data", dout, swap(IDC));
    chk("r036_pre_err", {31'd0, err}, 32'h1);
    chk("r036_pre_wb", wbstar, 32'h11111111);
    #2 rst_n = 1'b0;
    #1;
    chk("r036_data0", dout, 32'h0);
    chk("r036_flags0", {29'd0, synced, iprog, err}, 32'h0);
    chk("r036_wb0", wbstar, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 32'h30020001);
    cyc(0, 0, 32'hdeadbeef);
    chk("r036_post_wb", wbstar, 32'h0);
    chk("r036_post_sync", {31'd0, synced}, 32'h0);
    cyc(0, 0, SYNC);
    cyc(0, 0, 32'h30020001);
    cyc(0, 0, 32'h00000055);
    chk("r036_resync_wb", wbstar, 32'h00000055);

    // Deselect pause in WRDATA and RDPEND, RDOUT repeat, abort of a read by a header.
    cyc(0, 0, 32'h30020002);
    cyc(0, 0, 32'h0000aaaa);
    repeat (3) cyc(1, 0, $urandom);
    cyc(0, 0, 32'h0000bbbb);
    chk("pause_wr", wbstar, 32'h0000bbbb);
    cyc(0, 0, 32'h28020002);
    cyc(0, 0, 32'h20000000);
    cyc(1, 1, 32'h0);
    cyc(0, 1, 32'h0);
    chk("lat_rd1", dout, 32'h0);
    cyc(0, 1, 32'h0);
    chk("lat_rd2", dout, 32'h0);
    cyc(1, 1, 32'h0);
    cyc(0, 1, 32'h0);
    chk("lat_rd3", dout, swap(32'h0000bbbb));
    cyc(0, 1, 32'h0);
    chk("rdout_rd4", dout, swap(32'h0000bbbb));
    cyc(1, 0, 32'h0);
    cyc(0, 0, 32'h28020001);
    cyc(0, 0, 32'h20000000);
    cyc(1, 0, 32'h0);
    cyc(0, 0, 32'h30020001);
    cyc(0, 0, 32'h00000077);
    chk("rd_abort_hdr", wbstar, 32'h00000077);

    // Randomized packets against the model.
    use_model = 1;
    do_reset();
    for (int t = 0; t < 600; t++) begin
      case ($urandom_range(0, 11))
        0, 1: rcyc(0, SYNC);
        2: rcyc(0, ($urandom_range(0, 1) == 0) ? 32'h20000000 : 32'hffffffff);
        3, 4, 5: begin
          a = 5'($urandom);
          if ($urandom_range(0, 3) == 0) a = 5'd16;
          n = 11'($urandom_range(0, 3));
          rcyc(0, {3'b001, 2'b10, 9'd0, a, 2'b00, n});
          for (int j = 0; j < int'(n); j++) begin
            d = $urandom;
            if (a == 5'd4 && $urandom_range(0, 2) == 0)
              d = ($urandom_range(0, 1) == 0) ? 32'hd : 32'hf;
            rcyc(0, d);
          end
        end
        6, 7: begin
          sel = $urandom_range(0, 3);
          a = (sel == 0) ? 5'd12 : (sel == 1) ? 5'd16 : (sel == 2) ? 5'd4 : 5'($urandom);
          n = 11'($urandom_range(1, 3));
          rcyc(0, {3'b001, 2'b01, 9'd0, a, 2'b00, n});
          rcyc(0, 32'h20000000);
          cyc(1, 1, $urandom);
          repeat (RDLAT + int'(n) - 1 + $urandom_range(0, 1)) rcyc(1, $urandom);
          cyc(1, 0, $urandom);
        end
        8: rcyc(0, $urandom);
        9: rcyc(1, $urandom);
        10: cyc(1, 1'($urandom), $urandom);
        default: begin
          if ($urandom_range(0, 3) == 0) do_reset();
          else rcyc(0, SYNC);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
